// File: rtl/floating_point_operand_pairer.sv
// floating_point_operand_pairer
//   Collects a stream of floating-point operands into pairs for a two-input
//   adder. Operands are paired in the order they arrive: the earlier one goes
//   to fp_a_o and the later one to fp_b_o. When a group has an odd number of
//   operands, its last operand is paired with +0. Operand bits are never
//   inspected or altered.
//
// Ports
//   clk_i        : clock; all state changes on the rising edge
//   rst_i        : asynchronous active-high reset
//   fp_i         : incoming operand {sign, exponent, fraction}
//   valid_i      : fp_i / last_i are valid
//   last_i       : fp_i is the final operand of its group
//   ready_o      : an input is accepted this cycle when valid_i is also high
//   fp_a_o       : first operand of the pair
//   fp_b_o       : second operand of the pair
//   valid_o      : the pair on fp_a_o / fp_b_o / last_o is valid
//   ready_i      : downstream accepts the pair
//   last_o       : the pair closes a group
//   pair_count_o : number of pairs loaded since reset (wraps at 16 bits)
module floating_point_operand_pairer #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [EXP_WIDTH+FRAC_WIDTH:0]     fp_i,
  input  logic                              valid_i,
  input  logic                              last_i,
  output logic                              ready_o,
  output logic [EXP_WIDTH+FRAC_WIDTH:0]     fp_a_o,
  output logic [EXP_WIDTH+FRAC_WIDTH:0]     fp_b_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic                              last_o,
  output logic [15:0]                       pair_count_o
);

  localparam int W = 1 + EXP_WIDTH + FRAC_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   hold_q, hold_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           last_q, last_d;
  logic           valid_q, valid_d;
  logic [15:0]    count_q, count_d;

  logic           accept;
  logic           load;

  // The output register can take a new pair when it is empty or is being
  // drained by downstream in this same cycle.
  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    a_d     = a_q;
    b_d     = b_q;
    last_d  = last_q;
    count_d = count_q;
    load    = 1'b0;
    // Drop valid once downstream has taken the pair; a new load below
    // overrides this so back-to-back pairs keep valid high.
    valid_d = valid_q && !ready_i;

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (last_i) begin
            load   = 1'b1;
            a_d    = fp_i;
            b_d    = '0;
            last_d = 1'b1;
          end else begin
            hold_d  = fp_i;
            state_d = HOLD;
          end
        end
        HOLD: begin
          load    = 1'b1;
          a_d     = hold_q;
          b_d     = fp_i;
          last_d  = last_i;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (load) begin
      valid_d = 1'b1;
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hold_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      a_q     <= a_d;
      b_q     <= b_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign fp_a_o       = a_q;
  assign fp_b_o       = b_q;
  assign last_o       = last_q;
  assign valid_o      = valid_q;
  assign pair_count_o = count_q;

endmodule
